// File: rtl/msk_and_hpc1_stream.sv
// rtl/msk_and_hpc1_stream.sv - two-stage pipelined masked AND (HPC1: SNI refresh + DOM multiply)
//
// Purpose: per lane, takes d-share sharings of a and b and produces a d-share
// sharing of a&b. Stage 1 registers ina together with a pairwise-refreshed inb.
// Stage 2 registers all d*d DOM cross terms, with the off-diagonal ones masked.
// out is the XOR-compression of the stage-2 terms for each share.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake (ina, inb, rnd_ref sampled on accept)
//   ina, inb          d*nbits sharings, lane i share j at bit i*d+j
//   rnd_ref           refresh randomness, nrnd bits per lane, used on accept
//   rnd_mul           DOM randomness, nrnd bits per lane, used on stage 1->2 move
//   out_valid/out_ready output handshake
//   out               d*nbits sharing of a&b
//   op_count          16-bit wrapping count of output handshakes
//                     (present only with MSKAND_HPC1_STREAM_CNT_EN defined)

module msk_and_hpc1_stream #(
    parameter int d     = 2,
    parameter int nbits = 1,
    localparam int nrnd = d * (d - 1) / 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [d*nbits-1:0]    ina,
    input  logic [d*nbits-1:0]    inb,
    input  logic [nrnd*nbits-1:0] rnd_ref,
    input  logic [nrnd*nbits-1:0] rnd_mul,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef MSKAND_HPC1_STREAM_CNT_EN
    output logic [15:0]           op_count,
`endif
    output logic [d*nbits-1:0]    out
);

    // Random-bit index of share pair (j,k), j<k, enumerated row by row.
    function automatic int pidx(input int j, input int k);
        return j * d - (j * (j + 1)) / 2 + (k - j - 1);
    endfunction

    logic                   v1_q, v1_d;
    logic                   v2_q, v2_d;
    logic [d*nbits-1:0]     a1_q, a1_d;
    logic [d*nbits-1:0]     b1_q, b1_d;
    // Cross term (lane i, share j of a, share k of b) at bit (i*d+j)*d+k.
    logic [d*d*nbits-1:0]   t_q, t_d;
    logic                   accept;
    logic                   load2;

    assign load2     = v1_q && (!v2_q || out_ready);
    assign in_ready  = !v1_q || !v2_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = v2_q;

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        a1_d = a1_q;
        b1_d = b1_q;
        t_d  = t_q;

        if (accept) begin
            v1_d = 1'b1;
        end else if (load2) begin
            v1_d = 1'b0;
        end

        if (load2) begin
            v2_d = 1'b1;
        end else if (out_ready) begin
            v2_d = 1'b0;
        end

        if (accept) begin
            a1_d = ina;
            b1_d = inb;
            // Each pair's random bit lands on both of its shares, so the
            // refreshed sharing still XORs to b.
            for (int i = 0; i < nbits; i++) begin
                for (int j = 0; j < d; j++) begin
                    for (int k = j + 1; k < d; k++) begin
                        b1_d[i*d+j] = b1_d[i*d+j] ^ rnd_ref[i*nrnd+pidx(j, k)];
                        b1_d[i*d+k] = b1_d[i*d+k] ^ rnd_ref[i*nrnd+pidx(j, k)];
                    end
                end
            end
        end

        if (load2) begin
            for (int i = 0; i < nbits; i++) begin
                for (int j = 0; j < d; j++) begin
                    for (int k = 0; k < d; k++) begin
                        t_d[(i*d+j)*d+k] = a1_q[i*d+j] & b1_q[i*d+k];
                        if (j < k) begin
                            t_d[(i*d+j)*d+k] = t_d[(i*d+j)*d+k] ^ rnd_mul[i*nrnd+pidx(j, k)];
                        end else if (j > k) begin
                            t_d[(i*d+j)*d+k] = t_d[(i*d+j)*d+k] ^ rnd_mul[i*nrnd+pidx(k, j)];
                        end
                    end
                end
            end
        end
    end

    // Domains are only mixed here, after the stage-2 register.
    always_comb begin
        logic acc;
        acc = 1'b0;
        out = '0;
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < d; j++) begin
                acc = 1'b0;
                for (int k = 0; k < d; k++) begin
                    acc = acc ^ t_q[(i*d+j)*d+k];
                end
                out[i*d+j] = acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            a1_q <= '0;
            b1_q <= '0;
            t_q  <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            a1_q <= a1_d;
            b1_q <= b1_d;
            t_q  <= t_d;
        end
    end

`ifdef MSKAND_HPC1_STREAM_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (v2_q && out_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign op_count = cnt_q;
`endif

endmodule
